// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the memory access controller.
// States, default widths and wait-counter sizing.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ACCESS,
    CAPT,
    RESP
  } state_e;

  // A wait of zero behaves as one, so size for at least one.
  function automatic int cnt_w(input int wait_cycles);
    int n;
    n = (wait_cycles < 1) ? 1 : wait_cycles;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the MAR/MDR/RAM memory datapath.
// Sequences strobes for one load or store per request handshake.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] bus_Data,
  output logic              MAR_enable,
  output logic              MDR_enable,
  output logic              read,
  output logic              write
);

  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = cnt_w(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WC - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic rdy_q, rdy_d;
  logic vld_q, vld_d;
  logic mar_q, mar_d;
  logic mdr_q, mdr_d;
  logic rd_q, rd_d;
  logic wen_q, wen_d;
  logic [DATA_W-1:0] bus_q, bus_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ADDR;
        end
      end
      ADDR:   state_d = wr_q ? DATA : ACCESS;
      DATA:   state_d = ACCESS;
      ACCESS: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = wr_q ? RESP : CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPT: begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rdy_d = 1'b0;
    vld_d = 1'b0;
    mar_d = 1'b0;
    mdr_d = 1'b0;
    rd_d  = 1'b0;
    wen_d = 1'b0;
    bus_d = bus_q;
    unique case (state_d)
      IDLE: begin
        rdy_d = 1'b1;
        bus_d = '0;
      end
      ADDR: begin
        mar_d = 1'b1;
        bus_d = DATA_W'(addr_d);
      end
      DATA: begin
        mdr_d = 1'b1;
        bus_d = wdata_d;
      end
      ACCESS: begin
        if (wr_d) begin
          wen_d = 1'b1;
        end else begin
          rd_d  = 1'b1;
          mdr_d = 1'b1;
        end
      end
      RESP:    vld_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      mar_q   <= 1'b0;
      mdr_q   <= 1'b0;
      rd_q    <= 1'b0;
      wen_q   <= 1'b0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      bus_q   <= bus_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign req_ready  = rdy_q;
  assign rsp_valid  = vld_q;
  assign rsp_rdata  = rdata_q;
  assign bus_Data   = bus_q;
  assign MAR_enable = mar_q;
  assign MDR_enable = mdr_q;
  assign read       = rd_q;
  assign write      = wen_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a MAR/MDR/RAM datapath model.
// Instances use wait settings 1, 3 and 0 on shared request inputs.
module tb_mem_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;

  logic          rdy [N];
  logic          vld [N];
  logic          mar [N];
  logic          mdr [N];
  logic          rd  [N];
  logic          wr  [N];
  logic [DW-1:0] rdat[N];
  logic [DW-1:0] bus [N];
  logic [DW-1:0] mrd [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk(clk),
      .clr(clr),
      .req_valid(req_valid),
      .req_ready(rdy[g]),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(vld[g]),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rdat[g]),
      .mem_rdata(mrd[g]),
      .bus_Data(bus[g]),
      .MAR_enable(mar[g]),
      .MDR_enable(mdr[g]),
      .read(rd[g]),
      .write(wr[g])
    );
  end

  // Memory datapath driven by instance 0
  logic          dp_init = 1'b1;
  logic [AW-1:0] dp_mar  = '0;
  logic [DW-1:0] dp_mdr  = '0;
  logic [DW-1:0] ram [512];

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 512; i++)
        ram[i] <= (i == 18) ? 32'hDEADBEEF : 32'h0;
    end else begin
      if (mar[0]) dp_mar <= bus[0][AW-1:0];
      if (mdr[0]) dp_mdr <= rd[0] ? ram[dp_mar] : bus[0];
      if (wr[0])  ram[dp_mar] <= dp_mdr;
    end
  end

  assign mrd[0] = dp_mdr;
  assign mrd[1] = 32'h1111_1111;
  assign mrd[2] = 32'h2222_2222;

  int vec_n = 0;
  int bad_n = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Strobe exclusivity on every instance
  always @(negedge clk) begin
    if (!clr && !dp_init) begin
      for (int g = 0; g < N; g++) begin
        vec_n++;
        if ((rd[g] & wr[g]) | (mar[g] & (rd[g] | wr[g]))
            | (rdy[g] & vld[g])) begin
          bad_n++;
          $display("FAIL excl[%0d]: rd=%b wr=%b mar=%b rdy=%b vld=%b",
                   g, rd[g], wr[g], mar[g], rdy[g], vld[g]);
        end
      end
    end
  end

  int acc_n = 0;
  int hs_n  = 0;
  always @(posedge clk) begin
    if (!clr) begin
      if (req_valid && rdy[0]) acc_n++;
      if (vld[0] && rsp_ready) hs_n++;
    end
  end

  // Reference: word memory plus the last completed load
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] last_load = '0;

  function automatic logic [31:0] model(input logic w,
    input logic [8:0] a, input logic [31:0] d);
    if (w) ref_mem[a] = d;
    else   last_load = ref_mem[a];
    return last_load;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!rdy[0] && k < 20) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(rdy[0]), 32'd1);
  endtask

  logic [5:0]    tr_f [16];
  logic [DW-1:0] tr_b [16];

  function automatic logic [5:0] flags0();
    return {vld[0], rdy[0], mar[0], mdr[0], rd[0], wr[0]};
  endfunction

  task automatic run_txn(input logic w, input logic [8:0] a,
    input logic [31:0] d, output int lat);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tr_f[c] = flags0();
      tr_b[c] = bus[0];
      if (vld[0]) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    int first_v[N];
    int first_rd[N];
    int rd_n[N];
    int acc0, hs0, issued, k;
    logic w;
    logic [8:0] a;
    logic [31:0] d, e;

    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    ref_mem[18] = 32'hDEADBEEF;

    tbl[0] = '{1'b0, 9'h012, 32'h0,         32'hDEADBEEF};
    tbl[1] = '{1'b1, 9'h1FF, 32'hA5A5_0001, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 9'h1FF, 32'h0,         32'hA5A5_0001};
    tbl[3] = '{1'b0, 9'h000, 32'h0,         32'h0};
    tbl[4] = '{1'b1, 9'h000, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{1'b0, 9'h000, 32'h0,         32'hFFFF_FFFF};
    tbl[6] = '{1'b1, 9'h012, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[7] = '{1'b0, 9'h012, 32'h0,         32'h1234_5678};

    repeat (3) @(posedge clk);
    #1;
    dp_init = 1'b0;
    clr = 1'b0;
    step();
    chk("rst_flags", 32'(flags0()), 32'b010000);
    chk("rst_bus", bus[0], 32'h0);
    chk("rst_rdata", rdat[0], 32'h0);

    for (int i = 0; i < 8; i++) begin
      wait_idle();
      void'(model(tbl[i].w, tbl[i].a, tbl[i].d));
      run_txn(tbl[i].w, tbl[i].a, tbl[i].d, lat);
      chk($sformatf("t%0d_lat", i), lat, 4);
      chk($sformatf("t%0d_c1", i), 32'(tr_f[1]), 32'b001000);
      chk($sformatf("t%0d_c1bus", i), tr_b[1], 32'(tbl[i].a));
      if (tbl[i].w) begin
        chk($sformatf("t%0d_c2", i), 32'(tr_f[2]), 32'b000100);
        chk($sformatf("t%0d_c2bus", i), tr_b[2], tbl[i].d);
        chk($sformatf("t%0d_c3", i), 32'(tr_f[3]), 32'b000001);
      end else begin
        chk($sformatf("t%0d_c2", i), 32'(tr_f[2]), 32'b000110);
        chk($sformatf("t%0d_c3", i), 32'(tr_f[3]), 32'b000000);
      end
      chk($sformatf("t%0d_rdata", i), rdat[0], tbl[i].exp);
      step();
      chk($sformatf("t%0d_back", i), 32'(flags0()), 32'b010000);
    end

    // Wait-length comparison across the three instances
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    last_load = '0;
    e = model(1'b0, 9'h012, 32'h0);
    for (int g = 0; g < N; g++) begin
      first_v[g] = -1;
      first_rd[g] = -1;
      rd_n[g] = 0;
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 9'h012;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      for (int g = 0; g < N; g++) begin
        if (rd[g]) begin
          rd_n[g]++;
          if (first_rd[g] < 0) first_rd[g] = c;
        end
        if (vld[g] && first_v[g] < 0) first_v[g] = c;
      end
      if (c == 4) chk("w1_rdata", rdat[0], e);
      step();
    end
    chk("w1_lat", first_v[0], 4);
    chk("w3_lat", first_v[1], 6);
    chk("w0_lat", first_v[2], 4);
    chk("w1_rdn", rd_n[0], 1);
    chk("w3_rdn", rd_n[1], 3);
    chk("w0_rdn", rd_n[2], 1);
    chk("w3_rd1", first_rd[1], 2);
    chk("w0_rd1", first_rd[2], 2);

    // Response backpressure with a stray request during RESP
    wait_idle();
    rsp_ready = 1'b0;
    e = model(1'b0, 9'h1FF, 32'h0);
    run_txn(1'b0, 9'h1FF, 32'h0, lat);
    chk("bp_lat", lat, 4);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_hold%0d", j), 32'({vld[0], rdy[0]}), 32'b10);
      req_valid = (j == 2);
      req_write = 1'b1;
      req_addr  = 9'h0AA;
      req_wdata = 32'hBAD0_BAD0;
      step();
    end
    chk("bp_still", 32'({vld[0], rdy[0]}), 32'b10);
    chk("bp_rdata", rdat[0], e);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_idle", 32'({vld[0], rdy[0]}), 32'b01);
    e = model(1'b0, 9'h0AA, 32'h0);
    run_txn(1'b0, 9'h0AA, 32'h0, lat);
    chk("bp_next_lat", lat, 4);
    chk("bp_next_rdata", rdat[0], e);
    step();

    // Reset in the middle of a store access
    wait_idle();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 9'h012;
    req_wdata = 32'hCAFE_0055;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("clr_pre_wr", 32'(wr[0]), 32'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_flags", 32'(flags0()), 32'b010000);
    chk("clr_bus", bus[0], 32'h0);
    chk("clr_rdata", rdat[0], 32'h0);
    step();
    clr = 1'b0;
    last_load = '0;
    step();
    e = model(1'b0, 9'h012, 32'h0);
    run_txn(1'b0, 9'h012, 32'h0, lat);
    chk("clr_next_lat", lat, 4);
    chk("clr_next_rdata", rdat[0], e);
    step();

    // Random traffic against the reference model
    acc0 = acc_n;
    hs0 = hs_n;
    issued = 0;
    for (int t = 0; t < 60; t++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 3);
      a = (k == 0) ? 9'h000 : (k == 1) ? 9'h1FF : 9'($urandom_range(0, 15));
      d = $urandom;
      e = model(w, a, d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      step();
      issued++;
      lat = 0;
      for (int c = 1; c <= 12; c++) begin
        if (vld[0]) begin
          lat = c;
          break;
        end
        req_valid = ($urandom_range(0, 3) == 0);
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 9'($urandom);
        req_wdata = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
        step();
      end
      chk($sformatf("r%0d_lat", t), lat, 4);
      repeat ($urandom_range(0, 3)) begin
        rsp_ready = 1'b0;
        req_valid = 1'($urandom_range(0, 1));
        step();
        chk($sformatf("r%0d_hold", t), 32'(vld[0]), 32'd1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      chk($sformatf("r%0d_rdata", t), rdat[0], e);
      step();
      chk($sformatf("r%0d_idle", t), 32'({vld[0], rdy[0]}), 32'b01);
    end
    chk("acc_count", acc_n - acc0, issued);
    chk("hs_count", hs_n - hs0, issued);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the MAR/MDR/RAM memory subsystem. It accepts one load or store request from the control unit over a valid/ready handshake. It then sequences the MAR_enable, MDR_enable, read and write strobes and drives bus_Data, waits a fixed number of RAM cycles, and returns a response over a second valid/ready handshake. It sits between the control unit and the memory datapath and is the only driver of that datapath's control inputs.

Parameters:
ADDR_W, 9, word-address width (512-word RAM)
DATA_W, 32, data and bus width
WAIT_CYCLES, 1, cycles read or write is held in ACCESS; a value of 0 is treated as 1

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  transaction complete
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  DATA_W  load data; held until the next load completes
mem_rdata  in  DATA_W  MDR_Data from the memory datapath
bus_Data  out  DATA_W  value driven to MAR/MDR inputs
MAR_enable  out  1  MAR load strobe
MDR_enable  out  1  MDR load strobe
read  out  1  RAM read / MDR source select
write  out  1  RAM write strobe

Behaviour:
- Reset (clr=1, asynchronous, any state, including mid-transaction):
  - state goes to IDLE and the wait counter to 0.
  - addr/wdata/write capture registers and rsp_rdata go to 0.
  - All strobes are 0, bus_Data is 0, rsp_valid is 0, req_ready is 1 after release.
- Outputs are Moore-decoded from state. Only rsp_rdata and the capture registers are data registers.
- States:
  - IDLE: req_ready=1, all strobes 0, bus_Data=0. On req_valid, capture req_write/req_addr/req_wdata and go to ADDR.
  - ADDR: bus_Data = zero-extended captured addr; MAR_enable=1. Next state is DATA if write, else ACCESS.
  - DATA (stores only): bus_Data = captured wdata; MDR_enable=1; read=0. Go to ACCESS.
  - ACCESS: for a store, write=1. For a load, read=1 and MDR_enable=1. bus_Data holds its previous value. Stay WAIT_CYCLES cycles (counter counts 0..WAIT_CYCLES-1). On the last cycle go to CAPT if load, else RESP.
  - CAPT (loads only): all strobes 0. rsp_rdata <= mem_rdata at the end of the cycle. Go to RESP.
  - RESP: rsp_valid=1, strobes 0. Stay until rsp_ready=1, then go to IDLE.
- Latency: response appears 4 cycles after the accept edge for both load and store when WAIT_CYCLES=1; each extra wait cycle adds 1.
- read and write are never 1 in the same cycle. MAR_enable is never 1 together with read or write.
- A new request cannot be accepted in the RESP cycle (no back-to-back overlap). Minimum request period is 5 cycles.
- req_* inputs are ignored outside IDLE. Capture registers are stable for the whole transaction.
- A store leaves rsp_rdata unchanged.
- rsp_ready asserted outside RESP has no effect.

Decomposition:
- Shared package mem_ctrl_pkg contains:
  - state enum {IDLE, ADDR, DATA, ACCESS, CAPT, RESP}
  - ADDR_W/DATA_W defaults
  - wait-counter width function clog2(WAIT_CYCLES+1)
- Single module; no sub-module is needed. The wait counter is a small inline always block.

Test Plan:
- Reset release, then load addr=9'h012 with RAM[0x12]=32'hDEADBEEF, WAIT_CYCLES=1, rsp_ready=1:
  - Cycle sequence: MAR_enable=1 with bus_Data=32'h12, then read=MDR_enable=1.
  - rsp_valid=1 at accept+4 with rsp_rdata=32'hDEADBEEF.
- Store addr=9'h1FF, wdata=32'hA5A5_0001:
  - Strobe sequence: MAR_enable, then MDR_enable with read=0, then write=1.
  - rsp_valid at accept+4; a following load of 0x1FF returns 32'hA5A5_0001; rsp_rdata is unchanged by the store itself.
- WAIT_CYCLES=3 load: read is held 3 cycles and rsp_valid appears at accept+6. With WAIT_CYCLES=0, timing is identical to WAIT_CYCLES=1.
- Response backpressure: rsp_ready=0 for 5 cycles.
  - rsp_valid stays 1 and req_ready stays 0 throughout, and a req_valid pulse during RESP is ignored.
  - After rsp_ready=1, IDLE is entered and the next request is accepted.
- Assert clr during ACCESS of a store:
  - Same cycle: write=0 and all outputs return to reset values.
  - The next request completes normally.
- Assertion run with random requests:
  - read&write, MAR_enable&(read|write) and req_ready&rsp_valid are never 1.
  - Every accept yields exactly one rsp_valid handshake.
